// File: rtl/sata_xcvr_mc_reconf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sata_reconf_pkg
//  Description : Shared types and register map for the multi-channel SATA
//                generation-switch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package sata_reconf_pkg;

    // Sequencer states, in the order the MIF-streamer registers are written
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_LCH  = 4'd1,
        WR_OFS  = 4'd2,
        WR_DAT  = 4'd3,
        WR_CSR  = 4'd4,
        WR_OFS2 = 4'd5,
        WR_CSR2 = 4'd6,
        POLL    = 4'd7,
        DONE    = 4'd8
    } state_t;

    // Reconfiguration core MIF-streamer register map
    localparam logic [6:0]  LCH_ADDR      = 7'h38;
    localparam logic [6:0]  CSR_ADDR      = 7'h3A;
    localparam logic [6:0]  OFS_ADDR      = 7'h3B;
    localparam logic [6:0]  DAT_ADDR      = 7'h3C;

    localparam logic [31:0] CSR_WRITE     = 32'h1;
    localparam logic [31:0] CSR_MIF_START = 32'h1;
    localparam int          CSR_BUSY_BIT  = 8;
    localparam int          CSR_ERR_BIT   = 9;

    // Requested SATA generation encoding
    localparam logic [1:0]  GEN_ILLEGAL   = 2'd0;
    localparam logic [1:0]  GEN_SATA1     = 2'd1;
    localparam logic [1:0]  GEN_SATA2     = 2'd2;
    localparam logic [1:0]  GEN_SATA3     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sata_xcvr_mc_reconf_if.sv
`default_nettype none
// ============================================================================
//  Module      : sata_xcvr_mc_reconf_if
//  Description : 7-bit Avalon-MM management port of the shared transceiver
//                reconfiguration core.
//  Revision    : 1.0  initial release
// ============================================================================
interface sata_xcvr_mc_reconf_if;
    logic [6:0]  recfg_addr;
    logic        recfg_wreq;
    logic [31:0] recfg_wdat;
    logic        recfg_rreq;
    logic [31:0] recfg_rdat;
    logic        recfg_busy;

    modport master (
        output recfg_addr, recfg_wreq, recfg_wdat, recfg_rreq,
        input  recfg_rdat, recfg_busy
    );

    modport slave (
        input  recfg_addr, recfg_wreq, recfg_wdat, recfg_rreq,
        output recfg_rdat, recfg_busy
    );
endinterface
`default_nettype wire

// File: rtl/sata_xcvr_mc_reconf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sata_rr_arbiter
//  Description : Round-robin arbiter. Picks the first pending requester at or
//                after last_grant+1 (mod N) and registers the grant while
//                enabled; the grant holds while disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module sata_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_pend,
    input  logic [IW-1:0] i_last_grant,
    input  logic          i_en,
    output logic [IW-1:0] o_grant_idx,
    output logic [N-1:0]  o_grant_oh
);

    logic [IW-1:0] w_idx;
    logic          w_found;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_oh;

    function automatic int rr_pos(input int base, input int k);
        return (base + k) % N;
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest pending one wins
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_pend[rr_pos(int'(i_last_grant), k)]) begin
                w_idx   = IW'(rr_pos(int'(i_last_grant), k));
                w_found = 1'b1;
            end
        end
    end

    // Registered grant, only refreshed while the sequencer is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_oh  <= '0;
        end else if (i_en) begin
            r_idx <= w_idx;
            r_oh  <= w_found ? (N'(1) << w_idx) : '0;
        end
    end

    assign o_grant_idx = r_idx;
    assign o_grant_oh  = r_oh;

endmodule
`default_nettype wire

// File: rtl/sata_xcvr_mc_reconf.sv
`default_nettype none
// ============================================================================
//  Module      : sata_xcvr_mc_reconf
//  Description : Multi-channel SATA generation-switch sequencer. Accepts
//                per-channel switch requests, serialises them round-robin and
//                streams the matching MIF through the reconfiguration core,
//                then polls for completion with a saturating timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module sata_xcvr_mc_reconf
    import sata_reconf_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter int          TIMEOUT_W = 16,
    parameter logic [31:0] MIF_GEN1  = 32'h0000_0000,
    parameter logic [31:0] MIF_GEN2  = 32'h0000_0100,
    parameter logic [31:0] MIF_GEN3  = 32'h0000_0200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   cmd_request,
    input  logic [2*CHANNELS-1:0] cmd_sata_gen,
    output logic [CHANNELS-1:0]   cmd_ready,
    output logic [CHANNELS-1:0]   cmd_done,
    output logic [CHANNELS-1:0]   cmd_error,
    output logic                  seq_busy,
    sata_xcvr_mc_reconf_if.master bus
);

    localparam int                   c_iw       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [TIMEOUT_W-1:0] c_tmo_max  = '1;
    localparam logic [TIMEOUT_W-1:0] c_tmo_last = c_tmo_max - TIMEOUT_W'(1);

    state_t                r_state, w_state_nxt;
    logic                  r_gap;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic [CHANNELS-1:0]   r_pend, r_ready, r_done, r_error, w_accept;
    logic [1:0]            r_pend_gen [CHANNELS];
    logic [1:0]            w_gen      [CHANNELS];
    logic [c_iw-1:0]       r_last_grant, w_grant_idx;
    logic [CHANNELS-1:0]   w_grant_oh;
    logic [6:0]            w_addr;
    logic [31:0]           w_wdat, w_mif;
    logic                  w_wr, w_rd, w_poll_err, w_tmo_step, w_enter_done;
    logic                  w_unused_rdat;

    function automatic logic [31:0] mif_base(input logic [1:0] gen);
        case (gen)
            GEN_SATA1: return MIF_GEN1;
            GEN_SATA2: return MIF_GEN2;
            default:   return MIF_GEN3;
        endcase
    endfunction

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_gen
        assign w_gen[gi] = cmd_sata_gen[2*gi +: 2];
    end

    assign w_accept      = cmd_request & r_ready;
    assign w_mif         = mif_base(r_pend_gen[w_grant_idx]);
    assign w_enter_done  = (r_state == POLL) && (w_state_nxt == DONE);
    assign w_unused_rdat = ^{bus.recfg_rdat[31:10], bus.recfg_rdat[7:0]};

    sata_rr_arbiter #(.N(CHANNELS), .IW(c_iw)) u_arb (
        .clk          (clk),
        .rst          (reset),
        .i_pend       (r_pend),
        .i_last_grant (r_last_grant),
        .i_en         (r_state == IDLE),
        .o_grant_idx  (w_grant_idx),
        .o_grant_oh   (w_grant_oh)
    );

    // Next-state and bus drive; a strobe is withheld for one cycle after each completed access
    always_comb begin
        w_state_nxt = r_state;
        w_addr      = '0;
        w_wdat      = '0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_poll_err  = 1'b0;
        w_tmo_step  = 1'b0;
        case (r_state)
            IDLE:    if (|r_pend) w_state_nxt = WR_LCH;
            WR_LCH:  begin w_addr = LCH_ADDR; w_wdat = 32'(w_grant_idx); w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = WR_OFS;  end
            WR_OFS:  begin w_addr = OFS_ADDR; w_wdat = 32'h0;         w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = WR_DAT;  end
            WR_DAT:  begin w_addr = DAT_ADDR; w_wdat = w_mif;         w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = WR_CSR;  end
            WR_CSR:  begin w_addr = CSR_ADDR; w_wdat = CSR_WRITE;     w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = WR_OFS2; end
            WR_OFS2: begin w_addr = OFS_ADDR; w_wdat = 32'h1;         w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = WR_CSR2; end
            WR_CSR2: begin w_addr = CSR_ADDR; w_wdat = CSR_MIF_START; w_wr = !r_gap;
                           if (w_wr && !bus.recfg_busy) w_state_nxt = POLL;    end
            POLL: begin
                w_addr = CSR_ADDR;
                w_rd   = !r_gap;
                if (w_rd && !bus.recfg_busy) begin
                    if (bus.recfg_rdat[CSR_ERR_BIT]) begin
                        w_poll_err  = 1'b1;
                        w_state_nxt = DONE;
                    end else if (bus.recfg_rdat[CSR_BUSY_BIT]) begin
                        w_tmo_step = 1'b1;
                        if (r_tmo >= c_tmo_last) begin
                            w_poll_err  = 1'b1;
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, post-access gap flag, saturating poll counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gap        <= 1'b0;
            r_tmo        <= '0;
            r_last_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= (w_wr || w_rd) && !bus.recfg_busy;
            if (r_state == WR_CSR2)
                r_tmo <= '0;
            else if (w_tmo_step && (r_tmo != c_tmo_max))
                r_tmo <= r_tmo + TIMEOUT_W'(1);
            if (r_state == DONE)
                r_last_grant <= w_grant_idx;
        end
    end

    // Per-channel acceptance, pending latch, done pulse, sticky error and ready
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend  <= '0;
            r_ready <= '1;
            r_done  <= '0;
            r_error <= '0;
            for (int i = 0; i < CHANNELS; i++) r_pend_gen[i] <= GEN_ILLEGAL;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_accept[i]) begin
                    // An illegal generation completes immediately with error and is never arbitrated
                    r_pend_gen[i] <= w_gen[i];
                    r_pend[i]     <= (w_gen[i] != GEN_ILLEGAL);
                    r_done[i]     <= (w_gen[i] == GEN_ILLEGAL);
                    r_error[i]    <= (w_gen[i] == GEN_ILLEGAL);
                    r_ready[i]    <= 1'b0;
                end else begin
                    r_done[i] <= w_enter_done && w_grant_oh[i];
                    if (w_enter_done && w_grant_oh[i]) begin
                        r_error[i] <= w_poll_err;
                        r_pend[i]  <= 1'b0;
                    end
                    if (r_done[i]) r_ready[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.recfg_addr = w_addr;
    assign bus.recfg_wdat = w_wdat;
    assign bus.recfg_wreq = w_wr;
    assign bus.recfg_rreq = w_rd;
    assign cmd_ready      = r_ready;
    assign cmd_done       = r_done;
    assign cmd_error      = r_error;
    assign seq_busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sata_xcvr_mc_reconf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sata_xcvr_mc_reconf
//  Description : Self-checking bench: models the reconfiguration core with a
//                programmable waitrequest, and scoreboards bus accesses and
//                per-channel completions against expectations queued when
//                each request is driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sata_xcvr_mc_reconf;

    localparam int CH = 4;
    localparam int TW = 4;

    typedef struct packed {
        logic        rd;
        logic [6:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct packed {
        logic       err;
        logic [3:0] ch;
    } dn_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CH-1:0]   cmd_request = '0;
    logic [2*CH-1:0] cmd_sata_gen = '0;
    logic [CH-1:0]   cmd_ready, cmd_done, cmd_error;
    logic            seq_busy;

    acc_t exp_acc[$];
    dn_t  exp_dn[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_wait = 0;
    logic poll_busy = 1'b0;

    sata_xcvr_mc_reconf_if bus();

    sata_xcvr_mc_reconf #(.CHANNELS(CH), .TIMEOUT_W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_request  (cmd_request),
        .cmd_sata_gen (cmd_sata_gen),
        .cmd_ready    (cmd_ready),
        .cmd_done     (cmd_done),
        .cmd_error    (cmd_error),
        .seq_busy     (seq_busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Queue the full expected access stream and completion for one legal request
    task automatic push_seq(input int ch, input int gen, input bit tmo);
        logic [31:0] mif;
        mif = (gen == 1) ? 32'h0 : (gen == 2) ? 32'h100 : 32'h200;
        exp_acc.push_back('{1'b0, 7'h38, 32'(ch)});
        exp_acc.push_back('{1'b0, 7'h3B, 32'h0});
        exp_acc.push_back('{1'b0, 7'h3C, mif});
        exp_acc.push_back('{1'b0, 7'h3A, 32'h1});
        exp_acc.push_back('{1'b0, 7'h3B, 32'h1});
        exp_acc.push_back('{1'b0, 7'h3A, 32'h1});
        repeat (tmo ? 15 : 1) exp_acc.push_back('{1'b1, 7'h3A, 32'h0});
        exp_dn.push_back('{tmo, 4'(ch)});
    endtask

    task automatic req(input logic [CH-1:0] mask, input logic [2*CH-1:0] gens);
        int t = 0;
        @(negedge clk);
        while (((cmd_ready & mask) != mask) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
        cmd_request  = mask;
        cmd_sata_gen = gens;
        @(negedge clk);
        cmd_request  = '0;
    endtask

    task automatic wait_quiet(input int maxc);
        int t = 0;
        bit ok = 1'b0;
        while (t < maxc) begin
            @(negedge clk);
            t++;
            if (exp_acc.size() == 0 && exp_dn.size() == 0 && !seq_busy && cmd_ready == '1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("quiet", 32'(ok), 32'd1);
    endtask

    // Reconfiguration core model: waitrequest, stability, gap and access scoreboard
    bit   in_acc = 1'b0, last_cmpl = 1'b0, cap_rd;
    int   cnt = 0;
    logic [6:0]  cap_addr;
    logic [31:0] cap_data;
    always @(negedge clk) begin
        if (reset) begin
            in_acc = 1'b0;
            last_cmpl = 1'b0;
            bus.recfg_busy = 1'b0;
        end else begin
            if (last_cmpl) chk("strobe_gap", 32'(bus.recfg_wreq | bus.recfg_rreq), 32'd0);
            last_cmpl = 1'b0;
            if (bus.recfg_wreq || bus.recfg_rreq) begin
                if (!in_acc) begin
                    in_acc   = 1'b1;
                    cnt      = busy_wait;
                    cap_rd   = bus.recfg_rreq;
                    cap_addr = bus.recfg_addr;
                    cap_data = bus.recfg_wdat;
                end else begin
                    chk("hold_rd",   32'(bus.recfg_rreq), 32'(cap_rd));
                    chk("hold_addr", 32'(bus.recfg_addr), 32'(cap_addr));
                    chk("hold_wdat", bus.recfg_wdat, cap_data);
                end
                if (cnt > 0) begin
                    bus.recfg_busy = 1'b1;
                    cnt--;
                end else begin
                    bus.recfg_busy = 1'b0;
                    bus.recfg_rdat = poll_busy ? 32'h100 : 32'h0;
                    in_acc = 1'b0;
                    last_cmpl = 1'b1;
                    if (exp_acc.size() == 0) begin
                        chk("unexpected_access", 32'(bus.recfg_addr), 32'hFFFF_FFFF);
                    end else begin
                        acc_t e;
                        e = exp_acc.pop_front();
                        chk("acc_rd",   32'(bus.recfg_rreq), 32'(e.rd));
                        chk("acc_addr", 32'(bus.recfg_addr), 32'(e.addr));
                        if (!e.rd) chk("acc_wdat", bus.recfg_wdat, e.data);
                    end
                end
            end else begin
                if (in_acc) chk("access_dropped", 32'd0, 32'd1);
                in_acc = 1'b0;
                bus.recfg_busy = 1'b0;
            end
        end
    end

    // Completion scoreboard and ready-after-done tracking
    logic [CH-1:0] prev_done = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_done = '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (prev_done[i]) chk("ready_rise", 32'(cmd_ready[i]), 32'd1);
                if (cmd_done[i]) begin
                    chk("ready_low_at_done", 32'(cmd_ready[i]), 32'd0);
                    if (exp_dn.size() == 0) begin
                        chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        dn_t e;
                        e = exp_dn.pop_front();
                        chk("done_ch",  32'(i), 32'(e.ch));
                        chk("done_err", 32'(cmd_error[i]), 32'(e.err));
                    end
                end
            end
            prev_done = cmd_done;
        end
    end

    initial begin
        bus.recfg_busy = 1'b0;
        bus.recfg_rdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'hF);
        chk("rst_done",  32'(cmd_done), 32'h0);
        chk("rst_error", 32'(cmd_error), 32'h0);
        chk("rst_wreq",  32'(bus.recfg_wreq), 32'h0);
        chk("rst_rreq",  32'(bus.recfg_rreq), 32'h0);
        chk("rst_addr",  32'(bus.recfg_addr), 32'h0);
        chk("rst_wdat",  bus.recfg_wdat, 32'h0);
        chk("rst_busy",  32'(seq_busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Simultaneous requests with last_grant=0: served 1, 3, 0
        push_seq(1, 2, 1'b0);
        push_seq(3, 3, 1'b0);
        push_seq(0, 1, 1'b0);
        req(4'b1011, {2'd3, 2'd0, 2'd2, 2'd1});
        wait_quiet(600);

        // Single SATA3 request on channel 2
        push_seq(2, 3, 1'b0);
        req(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0});
        wait_quiet(300);
        chk("ch2_err", 32'(cmd_error[2]), 32'd0);

        // Same request with waitrequest held 5 cycles on every access
        busy_wait = 5;
        push_seq(2, 3, 1'b0);
        req(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0});
        wait_quiet(400);
        busy_wait = 0;

        // Illegal generation: immediate done with error, no bus traffic
        exp_dn.push_back('{1'b1, 4'd1});
        req(4'b0010, 8'h00);
        chk("ill_done", 32'(cmd_done[1]), 32'd1);
        chk("ill_err",  32'(cmd_error[1]), 32'd1);
        wait_quiet(100);

        // Poll always busy: 15 reads then error; the next request clears it
        poll_busy = 1'b1;
        push_seq(3, 2, 1'b1);
        req(4'b1000, {2'd2, 2'd0, 2'd0, 2'd0});
        wait_quiet(400);
        chk("tmo_err_sticky", 32'(cmd_error[3]), 32'd1);
        poll_busy = 1'b0;
        push_seq(3, 1, 1'b0);
        req(4'b1000, {2'd1, 2'd0, 2'd0, 2'd0});
        chk("err_cleared", 32'(cmd_error[3]), 32'd0);
        wait_quiet(300);
        chk("retry_err", 32'(cmd_error[3]), 32'd0);

        // Reset while the MIF base write is stalled
        begin
            bit seen = 1'b0;
            busy_wait = 20;
            push_seq(0, 1, 1'b0);
            req(4'b0001, 8'h01);
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (bus.recfg_wreq && bus.recfg_addr == 7'h3C) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("reach_wr_dat", 32'(seen), 32'd1);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("mid_rst_wreq",  32'(bus.recfg_wreq), 32'd0);
            chk("mid_rst_rreq",  32'(bus.recfg_rreq), 32'd0);
            chk("mid_rst_ready", 32'(cmd_ready), 32'hF);
            chk("mid_rst_done",  32'(cmd_done), 32'h0);
            exp_acc.delete();
            exp_dn.delete();
            @(posedge clk);
            #1;
            chk("mid_rst_no_done", 32'(cmd_done), 32'h0);
            chk("mid_rst_idle",    32'(seq_busy), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            busy_wait = 0;
        end

        // Recovery after reset
        push_seq(0, 2, 1'b0);
        req(4'b0001, 8'h02);
        wait_quiet(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
